// File: rtl/stage_counter_pkg.sv
// stage_counter_pkg
// Phase constants for the four-phase instruction-cycle sequencer. These
// encodings are also decoded by the control unit, so keep them stable.
// Contents:
//   PH_W                    width of the binary phase index
//   PH_FETCH/DECODE/EXEC/INC binary encodings of the four phases
//   PH_COUNT                number of phases (strobe vector width)
package stage_counter_pkg;

  localparam int PH_W     = 2;
  localparam int PH_COUNT = 4;

  localparam logic [PH_W-1:0] PH_FETCH  = 2'd0;
  localparam logic [PH_W-1:0] PH_DECODE = 2'd1;
  localparam logic [PH_W-1:0] PH_EXEC   = 2'd2;
  localparam logic [PH_W-1:0] PH_INC    = 2'd3;

endpackage

// File: rtl/stage_counter_phase_decode.sv
// stage_counter_phase_decode
// Purely combinational binary-to-one-hot decode of the phase index.
// Bit n of the output is high when the phase equals n, so bit 0 is fetch,
// bit 1 decode, bit 2 execute, bit 3 increment.
// Ports:
//   phase   in  PH_W      binary phase index
//   onehot  out PH_COUNT  one-hot strobe vector
module stage_counter_phase_decode
  import stage_counter_pkg::*;
(
  input  logic [PH_W-1:0]     phase,
  output logic [PH_COUNT-1:0] onehot
);

  for (genvar gi = 0; gi < PH_COUNT; gi++) begin : g_dec
    assign onehot[gi] = (phase == PH_W'(gi));
  end

endmodule

// File: rtl/stage_counter.sv
// stage_counter
// Four-phase instruction-cycle sequencer: fetch -> decode -> execute ->
// increment -> fetch. Exactly one phase strobe is high at any time; the
// strobes come straight from flops so they cannot glitch.
// Ports:
//   clk    in  1     system clock, rising edge
//   clr    in  1     asynchronous active-high clear, forces fetch
//   ce     in  1     count enable; phase holds when low
//   f      out 1     fetch strobe      (phase 0)
//   d      out 1     decode strobe     (phase 1)
//   e      out 1     execute strobe    (phase 2)
//   i      out 1     increment strobe  (phase 3)
//   phase  out PH_W  binary phase index
//   wrap   out 1     phase 3 with ce high: next edge returns to fetch
module stage_counter
  import stage_counter_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            ce,
  output logic            f,
  output logic            d,
  output logic            e,
  output logic            i,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);

  logic [PH_W-1:0]     phase_reg;
  logic [PH_W-1:0]     phase_next;
  logic [PH_COUNT-1:0] strobe_reg;
  logic [PH_COUNT-1:0] strobe_next;

  // 2-bit overflow provides the 3 -> 0 wrap; every encoding is a legal phase.
  always_comb begin
    phase_next = phase_reg;
    if (ce) begin
      phase_next = phase_reg + 2'd1;
    end
  end

  // The strobes are decoded from the next phase and registered alongside it,
  // so they always match the registered phase and switch cleanly at clk-to-Q.
  stage_counter_phase_decode u_decode (
    .phase  (phase_next),
    .onehot (strobe_next)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_reg  <= PH_FETCH;
      strobe_reg <= PH_COUNT'(1);
    end else begin
      phase_reg  <= phase_next;
      strobe_reg <= strobe_next;
    end
  end

  assign phase = phase_reg;
  assign f     = strobe_reg[PH_FETCH];
  assign d     = strobe_reg[PH_DECODE];
  assign e     = strobe_reg[PH_EXEC];
  assign i     = strobe_reg[PH_INC];

  // Combinational look-ahead for the control unit.
  assign wrap = (phase_reg == PH_INC) & ce;

endmodule

// File: tb/tb_stage_counter.sv
// tb_stage_counter
// Scoreboard bench for stage_counter. The stimulus process drives ce/clr on
// falling edges, advances a simple modulo-4 phase model and queues the
// expected state after the next rising edge; a monitor pops and compares
// just after each rising edge.
module tb_stage_counter;

  logic       clk;
  logic       clr;
  logic       ce;
  logic       f, d, e, i;
  logic [1:0] phase;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ph;
    bit wrap;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   ph_model;

  stage_counter dut (
    .clk   (clk),
    .clr   (clr),
    .ce    (ce),
    .f     (f),
    .d     (d),
    .e     (e),
    .i     (i),
    .phase (phase),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_state(input string name, input int exp_ph, input bit exp_wrap);
    logic [3:0] exp_str;
    logic [3:0] act_str;
    exp_str = 4'b0001 << exp_ph;
    act_str = {i, e, d, f};
    checks++;
    if (int'(phase) != exp_ph) begin
      errors++;
      $display("FAIL %s phase: got %0d expected %0d at %0t", name, phase, exp_ph, $time);
    end
    checks++;
    if (act_str !== exp_str) begin
      errors++;
      $display("FAIL %s strobes{i,e,d,f}: got %b expected %b at %0t", name, act_str, exp_str, $time);
    end
    checks++;
    if ((int'(f) + int'(d) + int'(e) + int'(i)) != 1) begin
      errors++;
      $display("FAIL %s onehot: got %b not one-hot at %0t", name, act_str, $time);
    end
    checks++;
    if (wrap !== exp_wrap) begin
      errors++;
      $display("FAIL %s wrap: got %b expected %b at %0t", name, wrap, exp_wrap, $time);
    end
  endtask

  // Monitor: compare the queued expectation just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      $display("edge t=%0t tag=%0d ce=%b clr=%b phase=%0d exp=%0d", $time, x.tag, ce, clr, phase, x.ph);
      check_state("edge", x.ph, x.wrap);
    end
  end

  // Edge with clr held high: no advance.
  task automatic reset_edge(input int tag);
    exp_t x;
    ph_model = 0;
    x.ph = 0; x.wrap = 1'b0; x.tag = tag;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Drive ce for the coming rising edge and queue the expected outcome.
  task automatic step(input logic c, input int tag);
    exp_t x;
    ce = c;
    ph_model = (ph_model + (c ? 1 : 0)) % 4;
    x.ph = ph_model; x.wrap = (ph_model == 3) && c; x.tag = tag;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    ce  = 1'b1;
    ph_model = 0;
    #1;
    check_state("reset_async", 0, 1'b0);

    // Two rising edges under reset with ce high.
    reset_edge(0);
    reset_edge(0);
    clr = 1'b0;

    // Free run: d, e, i, f, d.
    for (int k = 0; k < 5; k++) step(1'b1, 1);

    // Reach execute, hold three edges, then expect increment.
    step(1'b1, 2);
    for (int k = 0; k < 3; k++) step(1'b0, 2);
    step(1'b1, 2);

    // Move to decode, then clear asynchronously between edges.
    step(1'b1, 3);
    step(1'b1, 3);
    #10;
    clr = 1'b1;
    #1;
    check_state("clear_mid", 0, 1'b0);
    reset_edge(3);
    clr = 1'b0;
    step(1'b1, 3);

    // Random enable.
    for (int k = 0; k < 200; k++) step(1'($urandom_range(0, 1)), 4);

    // Drain: bounded wait for the monitor to empty the queue.
    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
